ar_access_sched: RTL and testbench

- Sequences the address register (AR) and the memory strobes for two requesters: the instruction-fetch unit and the data-access unit.
- Arbitrates between the two requesters and latches the winner's start address.
- Drives the AR controls (address onto bus, arload, arinc) and the memory read/write strobes; walks AR through multi-word bursts.
- Acknowledges each word to the owning requester. Sits between the controller's requesters and the ar/memory datapath.

---
 rtl/ar_access_sched.sv | 216 +++++++++++++++++++++
 tb/tb_ar_access_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ar_access_sched.sv
// -----------------------------------------------------------------------------
// ar_access_sched
//
// Purpose:
//   Arbitrates between the instruction-fetch and data-access requesters for a
//   shared address register (AR) and memory port. The winner's start address
//   is latched at grant, loaded into AR, and every word of the transaction is
//   given a memory strobe of MEM_LAT cycles. Fetch bursts of up to three words
//   advance AR with an increment strobe between words. Each word is
//   acknowledged to its owner, and the final word also carries a done pulse.
//
// Parameters:
//   MEM_LAT  cycles a memory strobe is held per word (1..15)
//   AW       address width, equal to the AR width
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   if_req/addr/len     fetch request, start address, word count (0 => 1)
//   d_req/addr/we       data request, address, write enable (single word)
//   ar_din, arload      address onto the AR input bus and AR load strobe
//   arinc               AR increment strobe between burst words
//   mem_rd, mem_wr      memory read / write strobes
//   if_gnt, d_gnt       current owner of AR and memory
//   if_ack, d_ack       one-cycle pulse on the last strobe cycle of each word
//   if_done, d_done     one-cycle pulse with the final ack of a transaction
//   busy                a transaction is in progress
// -----------------------------------------------------------------------------
module ar_access_sched #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned AW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic [1:0]    if_len,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic          d_we,
    output logic [AW-1:0] ar_din,
    output logic          arload,
    output logic          arinc,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          if_gnt,
    output logic          d_gnt,
    output logic          if_ack,
    output logic          d_ack,
    output logic          if_done,
    output logic          d_done,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ACCESS,
        S_STEP
    } state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } owner_t;

    // Strobe-cycle counter reload value: counts down to 0 on the last cycle.
    localparam logic [3:0] WAIT_INIT = 4'(MEM_LAT - 1);

    state_t          r_state;
    owner_t          r_owner;
    owner_t          r_last_owner;
    logic [AW-1:0]   r_addr;
    logic [1:0]      r_remaining;
    logic            r_we;
    logic [3:0]      r_wait;

    state_t          w_next_state;
    logic            w_win_valid;
    owner_t          w_winner;
    logic [1:0]      w_if_words;

    // -------------------------------------------------------------------------
    // Arbitration. Only meaningful in IDLE; a tie goes to the requester that
    // did not own the previous transaction so neither side can starve.
    // -------------------------------------------------------------------------
    always_comb begin
        w_win_valid = if_req | d_req;
        if (if_req && d_req) begin
            w_winner = (r_last_owner == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
        end else if (d_req) begin
            w_winner = OWN_DATA;
        end else begin
            w_winner = OWN_FETCH;
        end
        w_if_words = (if_len == 2'd0) ? 2'd1 : if_len;
    end

    // -------------------------------------------------------------------------
    // Next state and outputs. Every output is a decode of the registered state,
    // so reset forces all of them to 0 on the following cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path through
        // this block leaves one unassigned, which would infer a latch.
        w_next_state = r_state;
        ar_din       = '0;
        arload       = 1'b0;
        arinc        = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        if_ack       = 1'b0;
        d_ack        = 1'b0;
        if_done      = 1'b0;
        d_done       = 1'b0;
        busy         = (r_state != S_IDLE);
        if_gnt       = busy && (r_owner == OWN_FETCH);
        d_gnt        = busy && (r_owner == OWN_DATA);

        case (r_state)
            S_IDLE: begin
                if (w_win_valid) begin
                    w_next_state = S_LOAD;
                end
            end

            S_LOAD: begin
                arload       = 1'b1;
                ar_din       = r_addr;
                w_next_state = S_ACCESS;
            end

            S_ACCESS: begin
                // Fetches always read; data follows its latched write enable.
                mem_wr = (r_owner == OWN_DATA) && r_we;
                mem_rd = !mem_wr;
                if (r_wait == 4'd0) begin
                    if_ack = (r_owner == OWN_FETCH);
                    d_ack  = (r_owner == OWN_DATA);
                    if (r_remaining == 2'd1) begin
                        if_done      = (r_owner == OWN_FETCH);
                        d_done       = (r_owner == OWN_DATA);
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_STEP;
                    end
                end
            end

            S_STEP: begin
                arinc        = 1'b1;
                w_next_state = S_ACCESS;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and transaction registers. Request fields are captured only on the
    // IDLE -> LOAD transition, so requester changes while busy have no effect.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_FETCH;
            r_last_owner <= OWN_FETCH;
            r_addr       <= '0;
            r_remaining  <= 2'd0;
            r_we         <= 1'b0;
            r_wait       <= 4'd0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_win_valid) begin
                        r_owner      <= w_winner;
                        r_last_owner <= w_winner;
                        if (w_winner == OWN_DATA) begin
                            r_addr      <= d_addr;
                            r_remaining <= 2'd1;
                            r_we        <= d_we;
                        end else begin
                            r_addr      <= if_addr;
                            r_remaining <= w_if_words;
                            r_we        <= 1'b0;
                        end
                    end
                end

                S_LOAD: begin
                    r_wait <= WAIT_INIT;
                end

                S_ACCESS: begin
                    if (r_wait != 4'd0) begin
                        r_wait <= r_wait - 4'd1;
                    end
                end

                S_STEP: begin
                    r_wait      <= WAIT_INIT;
                    r_remaining <= r_remaining - 2'd1;
                end

                default: begin
                    r_wait <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ar_access_sched.sv
// -----------------------------------------------------------------------------
// tb_ar_access_sched
//
// Drives both requesters of ar_access_sched and checks it against a
// transaction-level model. At every grant the model records the transaction
// window (start cycle, word count, owner) and pushes one expected ack record
// per word into a scoreboard. A monitor on the falling edge compares the
// control outputs of every cycle with the window's arithmetic expectation and
// pops a record whenever the DUT acknowledges a word.
// -----------------------------------------------------------------------------
module tb_ar_access_sched;

    localparam int L  = 2;
    localparam int AW = 16;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [1:0]    if_len;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          d_we;
    logic [AW-1:0] ar_din;
    logic          arload;
    logic          arinc;
    logic          mem_rd;
    logic          mem_wr;
    logic          if_gnt;
    logic          d_gnt;
    logic          if_ack;
    logic          d_ack;
    logic          if_done;
    logic          d_done;
    logic          busy;

    ar_access_sched #(
        .MEM_LAT(L),
        .AW     (AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .if_req (if_req),
        .if_addr(if_addr),
        .if_len (if_len),
        .d_req  (d_req),
        .d_addr (d_addr),
        .d_we   (d_we),
        .ar_din (ar_din),
        .arload (arload),
        .arinc  (arinc),
        .mem_rd (mem_rd),
        .mem_wr (mem_wr),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt),
        .if_ack (if_ack),
        .d_ack  (d_ack),
        .if_done(if_done),
        .d_done (d_done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------ checks
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------- model
    typedef struct {
        bit          is_data;
        logic [15:0] addr;
        bit          last;
        int          cyc;
    } ack_rec_t;

    ack_rec_t    sb[$];
    int          next_free = 0;
    bit          last_data = 1'b0;
    int          m_start   = 0;
    int          m_n       = 0;
    bit          m_data    = 1'b0;
    bit          m_we      = 1'b0;
    logic [15:0] m_addr    = '0;

    // A transaction granted at edge e occupies cycles e .. e+N*(L+1)-1:
    // one load cycle, then per word L strobe cycles followed by a step cycle
    // (no step after the last word). The scheduler is back to sampling
    // requests at edge e+N*(L+1)+1, after one idle cycle.
    always @(posedge clk) begin : model
        bit pick_d;
        cyc = cyc + 1;
        if (rst) begin
            m_n       = 0;
            next_free = cyc + 1;
            last_data = 1'b0;
            sb.delete();
        end else if (cyc >= next_free && (if_req || d_req)) begin
            if (if_req && d_req) pick_d = !last_data;
            else                 pick_d = d_req;
            last_data = pick_d;
            m_data    = pick_d;
            m_start   = cyc;
            m_addr    = pick_d ? d_addr : if_addr;
            m_we      = pick_d ? d_we : 1'b0;
            m_n       = pick_d ? 1 : ((if_len == 2'd0) ? 1 : int'(if_len));
            for (int k = 0; k < m_n; k++) begin
                sb.push_back('{pick_d, 16'(m_addr + 16'(k)), (k == m_n - 1), cyc + (k + 1) * L + k});
            end
            next_free = cyc + m_n * (L + 1) + 1;
        end
    end

    // Expected {busy, if_gnt, d_gnt, arload, arinc, mem_rd, mem_wr, ar_din}.
    function automatic logic [22:0] exp_ctrl(input int c);
        logic [22:0] v;
        int o;
        int p;
        v = '0;
        if (m_n > 0 && c >= m_start && c < m_start + m_n * (L + 1)) begin
            o     = c - m_start;
            v[22] = 1'b1;
            v[21] = !m_data;
            v[20] = m_data;
            if (o == 0) begin
                v[19]   = 1'b1;
                v[15:0] = m_addr;
            end else begin
                p = (o - 1) % (L + 1);
                if (p == L) begin
                    v[18] = 1'b1;
                end else begin
                    v[17] = !(m_data && m_we);
                    v[16] = m_data && m_we;
                end
            end
        end
        return v;
    endfunction

    // ----------------------------------------------------------------- monitor
    logic [15:0] ar_m = '0;

    always @(negedge clk) begin : monitor
        ack_rec_t r;
        check("ctrl", {busy, if_gnt, d_gnt, arload, arinc, mem_rd, mem_wr, ar_din}, exp_ctrl(cyc));
        if (if_ack || d_ack || if_done || d_done) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {if_ack, d_ack, if_done, d_done}, 4'b0000);
            end else begin
                r = sb.pop_front();
                check("ack_owner", {if_ack, d_ack}, r.is_data ? 2'b01 : 2'b10);
                check("ack_cycle", cyc, r.cyc);
                check("ack_addr", ar_m, r.addr);
                check("ack_done", {if_done, d_done}, r.last ? (r.is_data ? 2'b01 : 2'b10) : 2'b00);
            end
        end
        // Track what AR holds: loads and increments take effect at the edge.
        if (arload)     ar_m = ar_din;
        else if (arinc) ar_m = ar_m + 16'd1;
    end

    // --------------------------------------------------------------- stimulus
    bit abort_now = 1'b0;

    // Raise a request and hold it until its done pulse (or an abort). With
    // keep set the request stays high for a back-to-back follow-up.
    task automatic issue(input bit is_data, input logic [15:0] addr, input logic [1:0] len,
                         input bit we, input bit keep, input bit scramble);
        bit got;
        bit aborted;
        got     = 1'b0;
        aborted = 1'b0;
        if (is_data) begin
            d_req = 1'b1; d_addr = addr; d_we = we;
        end else begin
            if_req = 1'b1; if_addr = addr; if_len = len;
        end
        for (int t = 0; t < 300 && !got && !aborted; t++) begin
            @(negedge clk);
            if (abort_now) aborted = 1'b1;
            else if (is_data ? d_done : if_done) got = 1'b1;
            else if (scramble && (is_data ? d_gnt : if_gnt)) begin
                if (is_data) begin d_addr = 16'($urandom); d_we = 1'($urandom); end
                else begin if_addr = 16'($urandom); if_len = 2'($urandom); end
            end
        end
        if (!got && !aborted) check("req_timeout", 1'b0, 1'b1);
        if (!keep || aborted) begin
            if (is_data) d_req = 1'b0;
            else         if_req = 1'b0;
        end
    endtask

    task automatic random_requester(input bit is_data, input int count);
        int g_next;
        for (int i = 0; i < count; i++) begin
            g_next = $urandom_range(0, 3);
            issue(is_data, 16'($urandom), 2'($urandom), 1'($urandom),
                  (g_next == 0) && (i < count - 1), 1'b1);
            repeat (g_next) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_len = '0;
        d_req = 1'b0; d_addr = '0; d_we = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed single transactions.
        issue(1'b0, 16'h0040, 2'd1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        issue(1'b0, 16'h0100, 2'd3, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        issue(1'b1, 16'h7FFE, 2'd0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        issue(1'b0, 16'hFFFF, 2'd2, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        issue(1'b0, 16'h1234, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Contention from reset: both held high, grants alternate D, F, D, F.
        rst = 1'b1;
        fork
            begin
                issue(1'b1, 16'h2000, 2'd0, 1'b1, 1'b1, 1'b0);
                issue(1'b1, 16'h2001, 2'd0, 1'b0, 1'b0, 1'b0);
            end
            begin
                issue(1'b0, 16'h3000, 2'd2, 1'b0, 1'b1, 1'b0);
                issue(1'b0, 16'h3010, 2'd1, 1'b0, 1'b0, 1'b0);
            end
            begin
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (2) @(negedge clk);

        // Reset during the second strobe window of a 3-word fetch.
        fork
            issue(1'b0, 16'h0200, 2'd3, 1'b0, 1'b0, 1'b0);
            begin
                for (int t = 0; t < 50 && !arinc; t++) @(negedge clk);
                @(negedge clk);
                rst       = 1'b1;
                abort_now = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        abort_now = 1'b0;
        fork
            issue(1'b1, 16'h4000, 2'd0, 1'b0, 1'b0, 1'b0);
            issue(1'b0, 16'h5000, 2'd1, 1'b0, 1'b0, 1'b0);
        join
        repeat (2) @(negedge clk);

        // Randomised traffic from both requesters.
        fork
            random_requester(1'b1, 40);
            random_requester(1'b0, 40);
        join

        repeat (10) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual cycle %0d required < 50000", cyc);
        $fatal(1);
    end

endmodule
